// File: rtl/riscv_div_issue.sv
// ----------------------------------------------------------------------------
// riscv_div_issue
//
// Operand-preparation and sequencing stage in front of the serial divider.
// A div/divu/rem/remu request is accepted in IDLE, the divisor is normalised
// (shift amount, shifted divisor, sign and zero flags) in PREP, a single
// issue strobe is sent to the divider in ISSUE, the result is collected in
// WAIT and presented downstream in RESP until it is taken. A kill aborts the
// operation at any stage after IDLE; a result already in flight is then
// swallowed when the divider delivers it.
//
// Ports
//   Clk_CI, Rst_RBI          clock (rising edge), async active-low reset
//   ReqVld_SI / ReqRdy_SO    request handshake (ready only in IDLE)
//   ReqOpA_DI, ReqOpB_DI     dividend, divisor
//   ReqOpCode_SI             0 divu, 1 div, 2 remu, 3 rem
//   Kill_SI                  abort current operation
//   DivOpA_DO .. DivOpCode_SO  prepared operands towards the divider
//   DivInVld_SO              one-cycle issue strobe
//   DivOutRdy_SO             result accept towards the divider (WAIT only)
//   DivOutVld_SI, DivRes_DI  divider result
//   RspVld_SO / RspRdy_SI    response handshake
//   RspRes_DO                registered result
// ----------------------------------------------------------------------------
module riscv_div_issue #(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned C_LOG_WIDTH = 6
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RBI,
    input  logic                   ReqVld_SI,
    output logic                   ReqRdy_SO,
    input  logic [C_WIDTH-1:0]     ReqOpA_DI,
    input  logic [C_WIDTH-1:0]     ReqOpB_DI,
    input  logic [1:0]             ReqOpCode_SI,
    input  logic                   Kill_SI,
    output logic [C_WIDTH-1:0]     DivOpA_DO,
    output logic [C_WIDTH-1:0]     DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
    output logic                   DivOpBIsZero_SO,
    output logic                   DivOpBSign_SO,
    output logic [1:0]             DivOpCode_SO,
    output logic                   DivInVld_SO,
    output logic                   DivOutRdy_SO,
    input  logic                   DivOutVld_SI,
    input  logic [C_WIDTH-1:0]     DivRes_DI,
    output logic                   RspVld_SO,
    input  logic                   RspRdy_SI,
    output logic [C_WIDTH-1:0]     RspRes_DO
);

    // One-hot encoding: every handshake output is a plain state flop.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_PREP  = 5'b00010,
        S_ISSUE = 5'b00100,
        S_WAIT  = 5'b01000,
        S_RESP  = 5'b10000
    } state_e;

    localparam logic [C_LOG_WIDTH-1:0] C_SHIFT_ONE = C_LOG_WIDTH'(1);
    localparam logic [C_LOG_WIDTH-1:0] C_SHIFT_MAX = C_LOG_WIDTH'(C_WIDTH - 1);

    state_e                   state_q;
    logic [C_WIDTH-1:0]       opa_q;
    logic [C_WIDTH-1:0]       opb_q;
    logic [1:0]               opcode_q;
    logic                     drop_q;
    logic [C_WIDTH-1:0]       div_opa_q;
    logic [C_WIDTH-1:0]       div_opb_q;
    logic [C_LOG_WIDTH-1:0]   div_shift_q;
    logic                     div_zero_q;
    logic                     div_sign_q;
    logic [1:0]               div_opcode_q;
    logic [C_WIDTH-1:0]       rsp_res_q;
    logic [C_LOG_WIDTH-1:0]   shift_d;

    // Number of leading zero bits; an all-zero word yields C_WIDTH.
    function automatic logic [C_LOG_WIDTH-1:0] lead_zeros(input logic [C_WIDTH-1:0] val);
        logic [C_LOG_WIDTH-1:0] cnt;
        logic                   found;
        cnt   = {C_LOG_WIDTH{1'b0}};
        found = 1'b0;
        for (int i = C_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (val[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + C_SHIFT_ONE;
                end
            end
        end
        return cnt;
    endfunction

    // Normalisation shift. For signed divisors the sign-extension bits are
    // inverted to zeros first, so the leading-zero count equals the number of
    // leading sign bits; minus one keeps the sign bit itself. B==0 and B==-1
    // both land on C_WIDTH-1 naturally. Unsigned zero is clamped explicitly.
    always_comb begin
        shift_d = C_SHIFT_MAX;
        if (opcode_q[0]) begin
            shift_d = lead_zeros(opb_q ^ {C_WIDTH{opb_q[C_WIDTH-1]}}) - C_SHIFT_ONE;
        end else if (opb_q == {C_WIDTH{1'b0}}) begin
            shift_d = C_SHIFT_MAX;
        end else begin
            shift_d = lead_zeros(opb_q);
        end
    end

    // Sequencer: state, operand capture, divider operands, drop flag, result.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q      <= S_IDLE;
            opa_q        <= {C_WIDTH{1'b0}};
            opb_q        <= {C_WIDTH{1'b0}};
            opcode_q     <= 2'b00;
            drop_q       <= 1'b0;
            div_opa_q    <= {C_WIDTH{1'b0}};
            div_opb_q    <= {C_WIDTH{1'b0}};
            div_shift_q  <= {C_LOG_WIDTH{1'b0}};
            div_zero_q   <= 1'b0;
            div_sign_q   <= 1'b0;
            div_opcode_q <= 2'b00;
            rsp_res_q    <= {C_WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ReqVld_SI) begin
                        opa_q    <= ReqOpA_DI;
                        opb_q    <= ReqOpB_DI;
                        opcode_q <= ReqOpCode_SI;
                        drop_q   <= 1'b0;
                        state_q  <= S_PREP;
                    end
                end
                S_PREP: begin
                    div_opa_q    <= opa_q;
                    div_opb_q    <= opb_q << shift_d;
                    div_shift_q  <= shift_d;
                    div_zero_q   <= (opb_q == {C_WIDTH{1'b0}});
                    div_sign_q   <= opb_q[C_WIDTH-1] & opcode_q[0];
                    div_opcode_q <= opcode_q;
                    // Killing before the issue strobe means the divider never sees it.
                    if (Kill_SI) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The strobe goes out regardless; a kill only marks the result for discard.
                    if (Kill_SI) begin
                        drop_q <= 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (DivOutVld_SI) begin
                        // A kill coinciding with the result still discards it.
                        if (drop_q || Kill_SI) begin
                            state_q <= S_IDLE;
                        end else begin
                            rsp_res_q <= DivRes_DI;
                            state_q   <= S_RESP;
                        end
                    end else if (Kill_SI) begin
                        drop_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (Kill_SI || RspRdy_SI) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ReqRdy_SO       = state_q[0];
    assign DivInVld_SO     = state_q[2];
    assign DivOutRdy_SO    = state_q[3];
    assign RspVld_SO       = state_q[4];
    assign RspRes_DO       = rsp_res_q;
    assign DivOpA_DO       = div_opa_q;
    assign DivOpB_DO       = div_opb_q;
    assign DivOpBShift_DO  = div_shift_q;
    assign DivOpBIsZero_SO = div_zero_q;
    assign DivOpBSign_SO   = div_sign_q;
    assign DivOpCode_SO    = div_opcode_q;

endmodule

// File: tb/tb_riscv_div_issue.sv
// ----------------------------------------------------------------------------
// Testbench for riscv_div_issue. A behavioural serial divider sits behind the
// DUT (valid while idle, busy shift+1 cycles after an issue strobe). Expected
// operand preparation and results are pushed to a scoreboard queue when a
// request is driven and compared when the DUT issues / responds.
// ----------------------------------------------------------------------------
module tb_riscv_div_issue;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  shift;
        logic [31:0] divb;
        logic        sign;
        logic        zero;
        logic [31:0] res;
    } exp_t;

    logic        Clk_CI;
    logic        Rst_RBI;
    logic        ReqVld_SI;
    logic        ReqRdy_SO;
    logic [31:0] ReqOpA_DI;
    logic [31:0] ReqOpB_DI;
    logic [1:0]  ReqOpCode_SI;
    logic        Kill_SI;
    logic [31:0] DivOpA_DO;
    logic [31:0] DivOpB_DO;
    logic [5:0]  DivOpBShift_DO;
    logic        DivOpBIsZero_SO;
    logic        DivOpBSign_SO;
    logic [1:0]  DivOpCode_SO;
    logic        DivInVld_SO;
    logic        DivOutRdy_SO;
    logic        DivOutVld_SI;
    logic [31:0] DivRes_DI;
    logic        RspVld_SO;
    logic        RspRdy_SI;
    logic [31:0] RspRes_DO;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    riscv_div_issue #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
        .Clk_CI          (Clk_CI),
        .Rst_RBI         (Rst_RBI),
        .ReqVld_SI       (ReqVld_SI),
        .ReqRdy_SO       (ReqRdy_SO),
        .ReqOpA_DI       (ReqOpA_DI),
        .ReqOpB_DI       (ReqOpB_DI),
        .ReqOpCode_SI    (ReqOpCode_SI),
        .Kill_SI         (Kill_SI),
        .DivOpA_DO       (DivOpA_DO),
        .DivOpB_DO       (DivOpB_DO),
        .DivOpBShift_DO  (DivOpBShift_DO),
        .DivOpBIsZero_SO (DivOpBIsZero_SO),
        .DivOpBSign_SO   (DivOpBSign_SO),
        .DivOpCode_SO    (DivOpCode_SO),
        .DivInVld_SO     (DivInVld_SO),
        .DivOutRdy_SO    (DivOutRdy_SO),
        .DivOutVld_SI    (DivOutVld_SI),
        .DivRes_DI       (DivRes_DI),
        .RspVld_SO       (RspVld_SO),
        .RspRdy_SI       (RspRdy_SI),
        .RspRes_DO       (RspRes_DO)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    // RISC-V M-extension division semantics, including /0 and overflow.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    ref_div = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'd1:    ref_div = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            2'd2:    ref_div = (b == 32'd0) ? a : a % b;
            default: ref_div = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
        endcase
    endfunction

    // Shift from the position of the highest significant bit.
    function automatic logic [5:0] ref_shift(input logic [1:0] op, input logic [31:0] b);
        int h;
        h = -1;
        for (int i = 0; i < 32; i++) begin
            if (op[0] ? (b[i] != b[31]) : b[i]) h = i;
        end
        if (h < 0) return 6'd31;
        return op[0] ? 6'(30 - h) : 6'(31 - h);
    endfunction

    function automatic exp_t make_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.op    = op;
        e.a     = a;
        e.b     = b;
        e.shift = ref_shift(op, b);
        e.divb  = b << e.shift;
        e.sign  = b[31] & op[0];
        e.zero  = (b == 32'd0);
        e.res   = ref_div(op, a, b);
        return e;
    endfunction

    function automatic exp_t lit_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [5:0] sh, input logic [31:0] divb,
                                     input logic sign, input logic zero, input logic [31:0] res);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.shift = sh; e.divb = divb;
        e.sign = sign; e.zero = zero; e.res = res;
        return e;
    endfunction

    // Behavioural divider: undoes the normalisation and computes the result.
    logic        dv_busy;
    logic [5:0]  dv_cnt;
    logic [31:0] dv_res;
    logic [31:0] dv_b;
    always_comb begin
        dv_b = DivOpBSign_SO || DivOpCode_SO[0] ? 32'($signed(DivOpB_DO) >>> DivOpBShift_DO)
                                                : (DivOpB_DO >> DivOpBShift_DO);
    end
    always @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            dv_busy      <= 1'b0;
            dv_cnt       <= 6'd0;
            dv_res       <= 32'd0;
            DivOutVld_SI <= 1'b1;
            DivRes_DI    <= 32'd0;
        end else if (dv_busy) begin
            if (dv_cnt == 6'd0) begin
                dv_busy      <= 1'b0;
                DivOutVld_SI <= 1'b1;
                DivRes_DI    <= dv_res;
            end else begin
                dv_cnt <= dv_cnt - 6'd1;
            end
        end else if (DivInVld_SO) begin
            dv_busy      <= 1'b1;
            dv_cnt       <= DivOpBShift_DO;
            DivOutVld_SI <= 1'b0;
            dv_res       <= ref_div(DivOpCode_SO, DivOpA_DO, dv_b);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one request from IDLE and follow it until the DUT is idle again.
    // kill_at: cycle after accept (1 = PREP) in which Kill_SI is raised, 0 = none.
    task automatic run_op(input exp_t e, input int rsp_delay, input int kill_at);
        int          n;
        int          rsp_cnt;
        int          exp_idle;
        int          exp_rsp;
        int          lat;
        logic        done;
        logic        issued;
        logic        popped;
        logic [31:0] held;
        check_eq("req_rdy_idle", 32'(ReqRdy_SO), 32'd1);
        ReqVld_SI    = 1'b1;
        ReqOpA_DI    = e.a;
        ReqOpB_DI    = e.b;
        ReqOpCode_SI = e.op;
        sb_q.push_back(e);
        lat = 32'(e.shift) + 5;
        n = 0; rsp_cnt = 0; done = 1'b0; issued = 1'b0; popped = 1'b0; held = 32'd0;
        while (!done && n < 100) begin
            @(negedge Clk_CI);
            n++;
            ReqVld_SI = 1'b0;
            Kill_SI   = 1'b0;
            RspRdy_SI = 1'b0;
            if (DivInVld_SO) begin
                issued = 1'b1;
                check_eq("issue_cycle", n, 32'd2);
                check_eq("div_opa",   DivOpA_DO, sb_q[0].a);
                check_eq("div_opb",   DivOpB_DO, sb_q[0].divb);
                check_eq("div_shift", 32'(DivOpBShift_DO), 32'(sb_q[0].shift));
                check_eq("div_sign",  32'(DivOpBSign_SO), 32'(sb_q[0].sign));
                check_eq("div_zero",  32'(DivOpBIsZero_SO), 32'(sb_q[0].zero));
                check_eq("div_op",    32'(DivOpCode_SO), 32'(sb_q[0].op));
            end
            if (ReqRdy_SO) begin
                done = 1'b1;
            end else begin
                if (n == 3) check_eq("div_out_rdy", 32'(DivOutRdy_SO), 32'd1);
                if (RspVld_SO) begin
                    rsp_cnt++;
                    if (rsp_cnt == 1) begin
                        check_eq("rsp_latency", n, lat);
                        check_eq("rsp_res", RspRes_DO, sb_q[0].res);
                        held = RspRes_DO;
                        void'(sb_q.pop_front());
                        popped = 1'b1;
                    end else begin
                        check_eq("rsp_hold", RspRes_DO, held);
                    end
                    if (rsp_cnt - 1 == rsp_delay) RspRdy_SI = 1'b1;
                end
                if (kill_at == n) Kill_SI = 1'b1;
            end
        end
        Kill_SI   = 1'b0;
        RspRdy_SI = 1'b0;
        if (!done) check_eq("op_timeout", 32'd0, 32'd1);
        if (kill_at == 1) begin
            exp_idle = 2; exp_rsp = 0;
        end else if (kill_at >= 2 && kill_at < lat) begin
            exp_idle = lat; exp_rsp = 0;
        end else if (kill_at >= lat) begin
            exp_idle = kill_at + 1; exp_rsp = kill_at - lat + 1;
        end else begin
            exp_idle = lat + rsp_delay + 1; exp_rsp = rsp_delay + 1;
        end
        check_eq("idle_cycle", n, exp_idle);
        check_eq("rsp_count", rsp_cnt, exp_rsp);
        check_eq("issued", 32'(issued), (kill_at == 1) ? 32'd0 : 32'd1);
        if (!popped && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    initial begin
        exp_t e;
        logic [31:0] rb;
        n_checks     = 0;
        n_errors     = 0;
        Rst_RBI      = 1'b0;
        ReqVld_SI    = 1'b0;
        ReqOpA_DI    = 32'd0;
        ReqOpB_DI    = 32'd0;
        ReqOpCode_SI = 2'd0;
        Kill_SI      = 1'b0;
        RspRdy_SI    = 1'b0;
        repeat (3) @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        @(negedge Clk_CI);
        check_eq("rst_req_rdy",  32'(ReqRdy_SO), 32'd1);
        check_eq("rst_rsp_vld",  32'(RspVld_SO), 32'd0);
        check_eq("rst_in_vld",   32'(DivInVld_SO), 32'd0);
        check_eq("rst_out_rdy",  32'(DivOutRdy_SO), 32'd0);
        check_eq("rst_rsp_res",  RspRes_DO, 32'd0);
        check_eq("rst_div_opb",  DivOpB_DO, 32'd0);
        check_eq("rst_div_sh",   32'(DivOpBShift_DO), 32'd0);

        // Directed cases with hand-derived expectations.
        run_op(lit_exp(2'd0, 32'd100, 32'd7, 6'd29, 32'hE000_0000, 1'b0, 1'b0, 32'd14), 0, 0);
        run_op(lit_exp(2'd2, 32'd100, 32'd7, 6'd29, 32'hE000_0000, 1'b0, 1'b0, 32'd2), 0, 0);
        run_op(lit_exp(2'd3, 32'hFFFF_FF9C, 32'd7, 6'd28, 32'h7000_0000, 1'b0, 1'b0, 32'hFFFF_FFFE), 0, 0);
        run_op(lit_exp(2'd1, 32'd6, 32'hFFFF_FFFF, 6'd31, 32'h8000_0000, 1'b1, 1'b0, 32'hFFFF_FFFA), 0, 0);
        run_op(lit_exp(2'd0, 32'd5, 32'd0, 6'd31, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF), 0, 0);
        run_op(lit_exp(2'd2, 32'd5, 32'd0, 6'd31, 32'd0, 1'b0, 1'b1, 32'd5), 0, 0);
        run_op(lit_exp(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd31, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000), 0, 0);
        run_op(lit_exp(2'd0, 32'hFFFF_FFFF, 32'h8000_0000, 6'd0, 32'h8000_0000, 1'b0, 1'b0, 32'd1), 0, 0);
        // Backpressure: 10 cycles without RspRdy.
        run_op(lit_exp(2'd0, 32'd100, 32'd7, 6'd29, 32'hE000_0000, 1'b0, 1'b0, 32'd14), 10, 0);
        // Kills: PREP, 5th WAIT cycle, ISSUE, RESP.
        run_op(make_exp(2'd0, 32'd100, 32'd7), 0, 1);
        run_op(make_exp(2'd0, 32'd100, 32'd7), 0, 7);
        run_op(make_exp(2'd1, 32'd1000, 32'd3), 0, 2);
        run_op(make_exp(2'd0, 32'd100, 32'd7), 5, 36);
        run_op(make_exp(2'd3, 32'd12345, 32'hFFFF_FFF9), 1, 0);

        // Reset in the middle of WAIT.
        ReqVld_SI    = 1'b1;
        ReqOpA_DI    = 32'd100;
        ReqOpB_DI    = 32'd7;
        ReqOpCode_SI = 2'd0;
        @(negedge Clk_CI);
        ReqVld_SI = 1'b0;
        repeat (9) @(negedge Clk_CI);
        Rst_RBI = 1'b0;
        #1;
        check_eq("mrst_rsp_vld", 32'(RspVld_SO), 32'd0);
        check_eq("mrst_out_rdy", 32'(DivOutRdy_SO), 32'd0);
        check_eq("mrst_in_vld",  32'(DivInVld_SO), 32'd0);
        check_eq("mrst_div_opa", DivOpA_DO, 32'd0);
        check_eq("mrst_div_opb", DivOpB_DO, 32'd0);
        check_eq("mrst_div_sh",  32'(DivOpBShift_DO), 32'd0);
        check_eq("mrst_flags",   32'({DivOpBIsZero_SO, DivOpBSign_SO, DivOpCode_SO}), 32'd0);
        check_eq("mrst_rsp_res", RspRes_DO, 32'd0);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        @(negedge Clk_CI);
        check_eq("mrst_req_rdy", 32'(ReqRdy_SO), 32'd1);
        run_op(make_exp(2'd0, 32'd100, 32'd7), 0, 0);

        // Random operations.
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'(-$urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            e = make_exp(2'($urandom_range(0, 3)), $urandom, rb);
            run_op(e, $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_div_issue.md
# riscv_div_issue

Operand-preparation and sequencing stage that sits directly upstream of the serial divider in the RISC-V ALU. It accepts div/divu/rem/remu requests through a valid/ready handshake and computes the normalisation shift, shifted divisor and sign/zero flags. It issues exactly one transaction to the divider, collects the result, and presents it downstream through a registered valid/ready output. It also supports killing an in-flight operation, for example on a pipeline flush.

## Interface
- C_WIDTH, 32, operand/result width
- C_LOG_WIDTH, 6, width of shift field; equals clog2(C_WIDTH+1)

- Clk_CI  in  1  clock, rising edge
- Rst_RBI  in  1  reset, asynchronous, active-low
- ReqVld_SI  in  1  request valid
- ReqRdy_SO  out  1  request ready; high only in IDLE
- ReqOpA_DI  in  C_WIDTH  dividend
- ReqOpB_DI  in  C_WIDTH  divisor
- ReqOpCode_SI  in  2  0 divu, 1 div, 2 remu, 3 rem
- Kill_SI  in  1  abort the current operation; its result is discarded
- DivOpA_DO  out  C_WIDTH  to divider OpA
- DivOpB_DO  out  C_WIDTH  shifted divisor, to divider OpB
- DivOpBShift_DO  out  C_LOG_WIDTH  shift amount
- DivOpBIsZero_SO  out  1  divisor == 0
- DivOpBSign_SO  out  1  divisor sign bit, gated by signed opcode
- DivOpCode_SO  out  2  opcode passthrough
- DivInVld_SO  out  1  issue strobe, one cycle
- DivOutRdy_SO  out  1  result-accept to divider
- DivOutVld_SI  in  1  divider result valid
- DivRes_DI  in  C_WIDTH  divider result
- RspVld_SO  out  1  response valid
- RspRdy_SI  in  1  response ready
- RspRes_DO  out  C_WIDTH  registered result

## Operation
- States: IDLE, PREP, ISSUE, WAIT, RESP. The reset state is IDLE.
- IDLE: ReqRdy_SO=1. When ReqVld_SI=1:
  - register A, B and opcode;
  - clear the drop flag;
  - go to PREP.
- PREP: compute the shift from the registered B.
  - Unsigned (OpCode[0]=0): shift = count of leading zeros of B. If B==0, shift = C_WIDTH-1.
  - Signed: shift = (count of leading bits equal to B[MSB]) - 1. If B==0 or B==-1, shift = C_WIDTH-1.
  - Register the divider outputs:
    - DivOpB_DO = B << shift (logical);
    - DivOpBSign_SO = B[MSB] & OpCode[0];
    - DivOpBIsZero_SO = (B==0);
    - DivOpA_DO = A;
    - DivOpCode_SO = opcode.
  - Divider outputs stay stable from PREP exit until the next accepted request.
  - Transition: go to ISSUE. If Kill_SI=1, go to IDLE instead; nothing is issued.
- ISSUE: DivInVld_SO=1 for exactly one cycle, then go to WAIT. Kill_SI here sets the drop flag; the issue still happens.
- WAIT: DivOutRdy_SO=1.
  - Kill_SI in any WAIT cycle sets the drop flag.
  - When DivOutVld_SI=1:
    - with the drop flag clear: capture DivRes_DI into RspRes_DO and go to RESP;
    - with the drop flag set: discard the result and go to IDLE.
- RESP: RspVld_SO=1; RspRes_DO is held.
  - RspRdy_SI=1: go to IDLE.
  - Kill_SI=1: go to IDLE, result dropped. Kill_SI has priority over RspRdy_SI.
- DivOutVld_SI is sampled only in WAIT. The divider reports valid while idle, so the value is ignored in every other state.
- Kill_SI has no effect in IDLE.
- At most one operation is in flight; a new request is accepted only in IDLE.
- Divide-by-zero and overflow results are produced by the divider and passed through unchanged.

## Timing
- Request accepted at cycle t. PREP at t+1, DivInVld_SO at t+2.
- The divider starts at t+3 and is busy shift+1 cycles. DivOutVld_SI arrives at t+4+shift and is captured that cycle.
- RspVld_SO is asserted at t+5+shift. Latency from accept to response valid is shift+5 cycles; the maximum is C_WIDTH+4.
- Throughput: the next request can be accepted in the cycle after the response handshake.
- Reset values of all outputs and registers are 0; state is IDLE, so ReqRdy_SO=1 out of reset.
- Reset mid-operation returns to IDLE immediately. The divider shares the same reset, so no stale result can be captured.

## Test plan
- **divu, no backpressure:** A=100, B=7 -> DivOpBShift=29, DivOpB=0xE0000000, RspRes=14, RspVld 34 cycles after accept.
- **remu and rem:** remu 100,7 -> 2. rem A=-100 (0xFFFFFF9C), B=7 -> DivOpBShift=28, DivOpB=0x70000000, DivOpBSign=0, RspRes=0xFFFFFFFE.
- **Signed divisor edge:** div A=6, B=-1 -> DivOpBShift=31, DivOpB=0x80000000, DivOpBSign=1, RspRes=0xFFFFFFFA.
- **Divide by zero:**
  - divu A=5, B=0 -> DivOpBIsZero=1, DivOpBShift=31, RspRes=0xFFFFFFFF.
  - remu A=5, B=0 -> RspRes=5.
- **Kill:**
  - Kill_SI in PREP -> no DivInVld pulse, back in IDLE next cycle.
  - Kill_SI in the 5th WAIT cycle -> RspVld never asserted, ReqRdy_SO=1 the cycle after DivOutVld.
- **Backpressure and reset:**
  - Hold RspRdy_SI=0 for 10 cycles in RESP -> RspRes stable, ReqRdy_SO=0 throughout.
  - Assert Rst_RBI low mid-WAIT -> all outputs 0, ReqRdy_SO=1 after release.
